cpu_counter_multi: RTL and testbench
====================================

Name: cpu_counter_multi

Overview:
Parametrised, loadable multi-mode counter for the CPU datapath: up, down, modulo-N and one-shot modes, with a programmable prescaler.
- CPU software loads the count through a write strobe (din/write_en) and programs a limit register for modulo mode.
- Outputs: current count, a terminal-count pulse, a sticky wrap flag for polling, and a running status.

Parameters:
WIDTH, 8, counter/din/dout/limit width (>=2)
DIV_W, 4, prescaler divide-register width
DIV_RESET, 0, reset value of prescaler divide register (0 = tick every enabled cycle)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
din  input  WIDTH  load data for count or limit
write_en  input  1  load din into count
limit_en  input  1  load din into limit register
div_en  input  1  load din[DIV_W-1:0] into prescaler divide register
mode  input  2  0 UP, 1 DOWN, 2 MODULO, 3 ONESHOT
enable  input  1  counting enable (gates prescaler)
clear_flag  input  1  clear sticky wrap_flag
dout  output  WIDTH  current count
tc  output  1  one-cycle terminal-count pulse
wrap_flag  output  1  sticky, set on every tc
running  output  1  counter active (always 1 except ONESHOT expired)

Behaviour:
- One clock, synchronous active-high reset. Reset values: dout=0, tc=0, wrap_flag=0, running=1, limit={WIDTH{1}}, div=DIV_RESET, prescaler count=0.
- Priority each edge: reset > write_en > tick-driven count update. limit_en and div_en are independent of this priority and may occur in the same cycle as write_en.
- Prescaler: counts enabled cycles 0..div. A tick is generated in the cycle where prescaler==div and enable=1; the prescaler then returns to 0.
  - enable=0 holds the prescaler and the count.
  - write_en clears the prescaler to 0.
  - div_en clears the prescaler to 0.
- Load: write_en sets dout<=din, running<=1, tc<=0, independent of enable. A load suppresses any tick in the same cycle.
- On a tick, per mode:
  - UP: dout+1. At all-ones, wraps to 0 and fires tc.
  - DOWN: dout-1. At 0, wraps to all-ones and fires tc.
  - MODULO: if dout>=limit, dout<=0 and fire tc; else dout+1. A limit change mid-count takes effect on the next tick. A count above a newly lowered limit wraps to 0 on the next tick.
  - ONESHOT: dout-1 while running. Ticking at dout==0 fires tc, sets running<=0 and holds dout=0. Further ticks do nothing until write_en. Leaving ONESHOT mode sets running<=1 on the next edge.
- tc is registered: high for exactly the one cycle in which dout first shows the wrapped/terminal value; otherwise 0.
- wrap_flag: set on the edge that raises tc. If clear_flag and a tc set coincide, set wins. Otherwise clear_flag clears it.
- Mode change takes effect on the next tick; there is no reset of the count on mode change.
- Latency: dout updates on the clock edge at which the tick/load is sampled; no combinational din->dout path.
- All arithmetic is modulo 2^WIDTH, unsigned.

Decomposition:
- Package cpu_counter_pkg:
  - typedef enum logic [1:0] cnt_mode_t {CNT_UP, CNT_DOWN, CNT_MODULO, CNT_ONESHOT}
  - default parameter constants
- Sub-module cpu_counter_prescaler (clock, reset, enable, div, div_load, clr -> tick): holds the prescaler register and compare.
- Top level holds count, limit, flags and the mode case statement.

Test Plan:
- UP, div=0, enable=1, load 0xFE -> dout FE, FF, 00 with tc=1 on the 00 cycle only, then 01; wrap_flag=1 until clear_flag.
- DOWN, load 0x01, enable=1 -> 01, 00, FF with tc=1 on the FF cycle; tc pulse and clear_flag in the same cycle -> wrap_flag stays 1.
- MODULO, limit=5, load 0 -> 0,1,2,3,4,5,0 with tc on the 0; mid-count at 4, set limit=2 -> next tick gives 0 with tc.
- ONESHOT, load 3 -> 3,2,1,0 then hold 0, running=0, tc exactly once; write_en din=2 -> running=1, counts 2,1,0 again.
- Prescaler: div=3, UP from 0 with enable=1 -> dout increments every 4th cycle; enable low for 2 cycles stretches that interval by 2; write_en mid-interval restarts the 4-cycle spacing.
- reset asserted mid-count (dout=0x37, wrap_flag=1, limit=5, div=3) -> next edge dout=0, wrap_flag=0, running=1, limit=FF, div=0.

Source files
------------

// File: rtl/cpu_counter_pkg.sv
// Shared types and default parameter values for the multi-mode CPU counter.
package cpu_counter_pkg;

  typedef enum logic [1:0] {
    CNT_UP      = 2'd0,
    CNT_DOWN    = 2'd1,
    CNT_MODULO  = 2'd2,
    CNT_ONESHOT = 2'd3
  } cnt_mode_t;

  localparam int CNT_WIDTH_DEF     = 8;
  localparam int CNT_DIV_W_DEF     = 4;
  localparam int CNT_DIV_RESET_DEF = 0;

endpackage

// File: rtl/cpu_counter_prescaler.sv
// Programmable prescaler: holds the divide register and a cycle counter,
// and emits a tick on every (div+1)-th enabled cycle.
module cpu_counter_prescaler
  import cpu_counter_pkg::*;
#(
  parameter int DIV_W     = CNT_DIV_W_DEF,
  parameter int DIV_RESET = CNT_DIV_RESET_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  input  logic             clr,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_div_s;

  assign at_div_s = (cnt_q == div_q);
  assign tick     = enable & at_div_s;

  // Next-state for divide register and prescaler count (loads restart the interval).
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (div_load) begin
      div_d = div;
    end else begin
      div_d = div_q;
    end
    if (clr || div_load) begin
      cnt_d = {DIV_W{1'b0}};
    end else if (enable) begin
      if (at_div_s) begin
        cnt_d = {DIV_W{1'b0}};
      end else begin
        cnt_d = cnt_q + DIV_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= DIV_W'(DIV_RESET);
      cnt_q <= {DIV_W{1'b0}};
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_counter_multi.sv
// Loadable multi-mode counter (up/down/modulo/one-shot) with prescaler,
// terminal-count pulse, sticky wrap flag and running status.
module cpu_counter_multi
  import cpu_counter_pkg::*;
#(
  parameter int WIDTH     = CNT_WIDTH_DEF,
  parameter int DIV_W     = CNT_DIV_W_DEF,
  parameter int DIV_RESET = CNT_DIV_RESET_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             write_en,
  input  logic             limit_en,
  input  logic             div_en,
  input  logic [1:0]       mode,
  input  logic             enable,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             wrap_flag,
  output logic             running
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             running_q, running_d;
  logic             tick_s;
  cnt_mode_t        mode_s;

  assign mode_s = cnt_mode_t'(mode);

  cpu_counter_prescaler #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .div      (din[DIV_W-1:0]),
    .div_load (div_en),
    .clr      (write_en),
    .tick     (tick_s)
  );

  // Count/limit/flag next-state: load beats tick, tick advances per mode.
  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    running_d = running_q;
    limit_d   = limit_q;
    wrap_d    = wrap_q;

    if (limit_en) begin
      limit_d = din;
    end else begin
      limit_d = limit_q;
    end

    // Outside one-shot mode the counter is always considered active.
    if (mode_s != CNT_ONESHOT) begin
      running_d = 1'b1;
    end else begin
      running_d = running_q;
    end

    if (write_en) begin
      count_d   = din;
      running_d = 1'b1;
      tc_d      = 1'b0;
    end else if (tick_s) begin
      case (mode_s)
        CNT_UP: begin
          count_d = count_q + CNT_ONE;
          tc_d    = (count_q == CNT_ONES);
        end
        CNT_DOWN: begin
          count_d = count_q - CNT_ONE;
          tc_d    = (count_q == CNT_ZERO);
        end
        CNT_MODULO: begin
          if (count_q >= limit_q) begin
            count_d = CNT_ZERO;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
            tc_d    = 1'b0;
          end
        end
        CNT_ONESHOT: begin
          if (!running_q) begin
            count_d = count_q;
          end else if (count_q == CNT_ZERO) begin
            count_d   = CNT_ZERO;
            tc_d      = 1'b1;
            running_d = 1'b0;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end else begin
      count_d = count_q;
    end

    // A new terminal count wins over a simultaneous clear request.
    if (tc_d) begin
      wrap_d = 1'b1;
    end else if (clear_flag) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Counter state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= CNT_ZERO;
      limit_q   <= CNT_ONES;
      tc_q      <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      limit_q   <= limit_d;
      tc_q      <= tc_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign dout      = count_q;
  assign tc        = tc_q;
  assign wrap_flag = wrap_q;
  assign running   = running_q;

endmodule

// File: tb/tb_cpu_counter_multi.sv
// Directed self-checking bench for cpu_counter_multi (WIDTH=8, DIV_W=4).
module tb_cpu_counter_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       write_en;
  logic       limit_en;
  logic       div_en;
  logic [1:0] mode;
  logic       enable;
  logic       clear_flag;
  logic [7:0] dout;
  logic       tc;
  logic       wrap_flag;
  logic       running;

  int checks = 0;
  int errors = 0;

  cpu_counter_multi #(.WIDTH(8), .DIV_W(4), .DIV_RESET(0)) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .write_en   (write_en),
    .limit_en   (limit_en),
    .div_en     (div_en),
    .mode       (mode),
    .enable     (enable),
    .clear_flag (clear_flag),
    .dout       (dout),
    .tc         (tc),
    .wrap_flag  (wrap_flag),
    .running    (running)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Check dout, tc, wrap_flag, running in one go.
  task automatic chk(input string tag, input logic [7:0] d, input logic t, input logic w, input logic r);
    check_eq({tag, ".dout"}, 32'(dout), 32'(d));
    check_eq({tag, ".tc"}, 32'(tc), 32'(t));
    check_eq({tag, ".wrap"}, 32'(wrap_flag), 32'(w));
    check_eq({tag, ".run"}, 32'(running), 32'(r));
  endtask

  initial begin
    reset = 1'b1; din = 8'h00; write_en = 1'b0; limit_en = 1'b0; div_en = 1'b0;
    mode = 2'd0; enable = 1'b0; clear_flag = 1'b0;
    step();
    step();
    chk("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    // UP wrap
    mode = 2'd0; enable = 1'b1; din = 8'hFE; write_en = 1'b1;
    step(); chk("up_ld", 8'hFE, 1'b0, 1'b0, 1'b1);
    write_en = 1'b0;
    step(); chk("up_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
    step(); chk("up_00", 8'h00, 1'b1, 1'b1, 1'b1);
    step(); chk("up_01", 8'h01, 1'b0, 1'b1, 1'b1);
    clear_flag = 1'b1;
    step(); chk("up_clr", 8'h02, 1'b0, 1'b0, 1'b1);
    clear_flag = 1'b0;

    // DOWN wrap, clear coinciding with tc
    mode = 2'd1; din = 8'h01; write_en = 1'b1;
    step(); chk("dn_ld", 8'h01, 1'b0, 1'b0, 1'b1);
    write_en = 1'b0;
    step(); chk("dn_00", 8'h00, 1'b0, 1'b0, 1'b1);
    clear_flag = 1'b1;
    step(); chk("dn_ff_setwins", 8'hFF, 1'b1, 1'b1, 1'b1);
    step(); chk("dn_fe_clr", 8'hFE, 1'b0, 1'b0, 1'b1);
    clear_flag = 1'b0;

    // MODULO limit 5
    mode = 2'd2; enable = 1'b0; limit_en = 1'b1; din = 8'h05;
    step(); chk("mod_lim", 8'hFE, 1'b0, 1'b0, 1'b1);
    limit_en = 1'b0; din = 8'h00; write_en = 1'b1; enable = 1'b1;
    step(); chk("mod_ld", 8'h00, 1'b0, 1'b0, 1'b1);
    write_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(); chk("mod_cnt", 8'(i), 1'b0, 1'b0, 1'b1);
    end
    step(); chk("mod_wrap", 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(); chk("mod_cnt2", 8'(i), 1'b0, 1'b1, 1'b1);
    end
    enable = 1'b0; limit_en = 1'b1; din = 8'h02;
    step(); chk("mod_newlim", 8'h04, 1'b0, 1'b1, 1'b1);
    limit_en = 1'b0; enable = 1'b1;
    step(); chk("mod_lowered", 8'h00, 1'b1, 1'b1, 1'b1);
    clear_flag = 1'b1;
    step(); chk("mod_after", 8'h01, 1'b0, 1'b0, 1'b1);
    clear_flag = 1'b0;

    // ONESHOT
    mode = 2'd3; din = 8'h03; write_en = 1'b1;
    step(); chk("os_ld", 8'h03, 1'b0, 1'b0, 1'b1);
    write_en = 1'b0;
    step(); chk("os_2", 8'h02, 1'b0, 1'b0, 1'b1);
    step(); chk("os_1", 8'h01, 1'b0, 1'b0, 1'b1);
    step(); chk("os_0", 8'h00, 1'b0, 1'b0, 1'b1);
    step(); chk("os_term", 8'h00, 1'b1, 1'b1, 1'b0);
    step(); chk("os_hold", 8'h00, 1'b0, 1'b1, 1'b0);
    step(); chk("os_hold2", 8'h00, 1'b0, 1'b1, 1'b0);
    din = 8'h02; write_en = 1'b1;
    step(); chk("os_reld", 8'h02, 1'b0, 1'b1, 1'b1);
    write_en = 1'b0;
    step(); chk("os_r1", 8'h01, 1'b0, 1'b1, 1'b1);
    step(); chk("os_r0", 8'h00, 1'b0, 1'b1, 1'b1);
    step(); chk("os_rterm", 8'h00, 1'b1, 1'b1, 1'b0);
    mode = 2'd0; enable = 1'b0;
    step(); chk("os_leave", 8'h00, 1'b0, 1'b1, 1'b1);

    // Prescaler div=3
    clear_flag = 1'b1; div_en = 1'b1; din = 8'h03;
    step(); chk("ps_div", 8'h00, 1'b0, 1'b0, 1'b1);
    clear_flag = 1'b0; div_en = 1'b0; din = 8'h00; write_en = 1'b1; enable = 1'b1;
    step(); chk("ps_ld", 8'h00, 1'b0, 1'b0, 1'b1);
    write_en = 1'b0;
    step(); check_eq("ps_a1", 32'(dout), 32'h00);
    step(); check_eq("ps_a2", 32'(dout), 32'h00);
    step(); check_eq("ps_a3", 32'(dout), 32'h00);
    step(); check_eq("ps_a4", 32'(dout), 32'h01);
    step(); check_eq("ps_b1", 32'(dout), 32'h01);
    enable = 1'b0;
    step(); check_eq("ps_hold1", 32'(dout), 32'h01);
    step(); check_eq("ps_hold2", 32'(dout), 32'h01);
    enable = 1'b1;
    step(); check_eq("ps_b2", 32'(dout), 32'h01);
    step(); check_eq("ps_b3", 32'(dout), 32'h01);
    step(); check_eq("ps_b4", 32'(dout), 32'h02);
    step(); step();
    din = 8'h10; write_en = 1'b1;
    step(); check_eq("ps_reld", 32'(dout), 32'h10);
    write_en = 1'b0;
    step(); check_eq("ps_c1", 32'(dout), 32'h10);
    step(); check_eq("ps_c2", 32'(dout), 32'h10);
    step(); check_eq("ps_c3", 32'(dout), 32'h10);
    step(); check_eq("ps_c4", 32'(dout), 32'h11);

    // Reset mid-count
    enable = 1'b0; limit_en = 1'b1; din = 8'h05;
    step();
    limit_en = 1'b0; din = 8'h37; write_en = 1'b1; mode = 2'd1; enable = 1'b1;
    step();
    write_en = 1'b0; din = 8'h00;
    step(); step(); step(); step();
    check_eq("rs_pre_dout", 32'(dout), 32'h36);
    // Force wrap_flag via a DOWN wrap before reset: reload 0 and tick at div=3
    write_en = 1'b1;
    step();
    write_en = 1'b0;
    step(); step(); step(); step();
    chk("rs_pre", 8'hFF, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    step(); chk("rs_post", 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    // limit back to FF and div back to 0: MODULO from FE ticks every cycle to FF then 0
    mode = 2'd2; din = 8'hFE; write_en = 1'b1;
    step(); chk("rs_ld", 8'hFE, 1'b0, 1'b0, 1'b1);
    write_en = 1'b0;
    step(); chk("rs_lim_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
    step(); chk("rs_lim_wrap", 8'h00, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
